task_graph_streamer: RTL and testbench
======================================

# task_graph_streamer

Upstream feeder for `task_mapper`. Holds one application's task graph as an NUM_V×NUM_V adjacency matrix of edge weights and streams it row-major, one entry per slot, on the `task_array`/`row`/`col`/`root_task`/`app_end` interface that `task_mapper` consumes. Replays the same graph a programmable number of times back-to-back, replacing the bench-driven application loop in silicon.

## Interface
- `NUM_V`, 4: vertices per graph; matrix is NUM_V×NUM_V (NUM_V ≥ 2)
- `DATA_W`, 32: edge-weight width; 0 means no edge
- `IDX_W`, $clog2(NUM_V): row/col index width
- `CNT_W`, 10: width of the application repeat count

- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  asynchronous active-low reset
- `wr_en`  in  1  matrix write strobe; ignored while `busy`
- `wr_row`  in  IDX_W  write row; indices ≥ NUM_V are ignored
- `wr_col`  in  IDX_W  write column; indices ≥ NUM_V are ignored
- `wr_data`  in  DATA_W  edge weight to store
- `start`  in  1  one-cycle launch pulse; ignored while `busy`
- `app_count`  in  CNT_W  number of application passes; sampled with `start`
- `busy`  out  1  high from accepted `start` through the end of the final pass
- `done`  out  1  one-cycle pulse after the final pass
- `task_array`  out  DATA_W  current matrix entry
- `row`  out  IDX_W  row of current entry
- `col`  out  IDX_W  column of current entry
- `root_task`  out  1  marks the first nonzero entry of each pass
- `app_end`  out  1  end-of-application marker

## Operation
- Storage: NUM_V² × DATA_W registers, cleared by reset. Writes take effect on the next edge.
- FSM states: IDLE, EMIT, END, GAP, FIN.
- IDLE: `start`=1 with `app_count`≠0 latches the count, clears the index and `root_seen`, and goes to EMIT. `start` with `app_count`=0 goes to FIN; no stream is produced.
- EMIT: drives entry (row,col) for one slot of 2 cycles.
  - `root_task`=1 for the whole slot if the entry is nonzero and `root_seen`=0; `root_seen` is set at slot end.
  - At slot end, col increments; on col wrap, row increments and col returns to 0.
  - After entry (NUM_V−1,NUM_V−1), go to END.
- END: `app_end`=1 for 2 cycles. `task_array`/`row`/`col` hold the last entry (NUM_V−1,NUM_V−1). Then go to GAP.
- GAP: 1 cycle, all stream outputs low except `row`/`col`, which hold. The pass counter decrements.
  - If passes remain: reset index and `root_seen`, go to EMIT.
  - Otherwise go to FIN.
- FIN: `done`=1 for 1 cycle, `busy`=0, go to IDLE.
- An all-zero matrix never asserts `root_task`; the full stream and `app_end` still occur.
- `busy`=1 in EMIT, END and GAP.

## Timing
- Reset: all outputs 0. FSM in IDLE. Matrix, index, counters and `root_seen` cleared. Reset mid-pass aborts immediately, with no `done`.
- Launch latency: `start` sampled at edge t → first entry visible after edge t+1.
- Per-pass length: 2·NUM_V² + 3 cycles (EMIT + END + GAP). Consecutive passes have no further gap.
- `done` asserts on the cycle after the final GAP.
- All outputs are registered; no combinational path from any input to any output.
- `start` and `wr_en` are both ignored while `busy`=1, including in the same cycle as FIN.
- `start` and `wr_en` in the same IDLE cycle: both take effect. The stream uses the matrix content before that write.

## Configuration
- `TGS_SKIP_ZERO_EN`:
  - Defined: zero entries occupy a 1-cycle slot instead of 2; nonzero entries keep 2 cycles. Per-pass length becomes 2·nz + z + 3, where nz/z are the nonzero/zero entry counts.
  - Undefined: every slot is 2 cycles, as described in Operation and Timing.

## Test plan
- NUM_V=2, matrix {{0,5},{5,0}}, `app_count`=1, start at edge 0 (macro off):
  - Entries (0,0,0),(0,1,5),(1,0,5),(1,1,0), each held 2 cycles from edge 1.
  - `root_task` high only during the (0,1) slot.
  - `app_end` high for cycles 9–10, GAP at cycle 11, `done` at cycle 12.
- Same matrix, `app_count`=3: three identical 11-cycle passes, `root_task` once per pass, a single `done` at cycle 34.
- All-zero matrix, `app_count`=1: `root_task` never asserts; `app_end` and `done` timing are unchanged.
- `start` with `app_count`=0: `done` the next cycle, `busy` never rises. Also: `start` and `wr_en` pulsed mid-stream are ignored, leaving the output stream and matrix unchanged.
- Assert `rst_b`=0 during END of pass 1 of 2: all outputs 0 asynchronously, no `done`, matrix cleared. A new `start` after release streams zeros.
- Macro on, {{0,5},{5,0}}, `app_count`=1: slots of 1, 2, 2, 1 cycles, `app_end` at cycles 7–8, `done` at cycle 10.

Source files
------------

// File: rtl/task_graph_streamer.sv
// Holds one task graph as an NUM_V x NUM_V edge-weight matrix and replays it row-major, app_count times.
// Optional macro TGS_SKIP_ZERO_EN: zero entries take a 1-cycle slot instead of 2.
module task_graph_streamer #(
    parameter int NUM_V  = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(NUM_V),
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_row,
    input  logic [IDX_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [CNT_W-1:0]  app_count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] task_array,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic              root_task,
    output logic              app_end
);

    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_END, S_GAP, S_FIN} state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [NUM_V][NUM_V];

    logic [IDX_W-1:0]  cur_row, cur_col, row_nx, col_nx;
    logic              phase, phase_nx;
    logic [CNT_W-1:0]  passes, passes_nx;
    logic              root_seen, root_seen_nx;

    logic              pend_valid;
    logic [IDX_W-1:0]  pend_row, pend_col;
    logic [DATA_W-1:0] pend_data;

    logic              busy_nx, done_nx, root_nx, app_end_nx;
    logic [DATA_W-1:0] task_nx;
    logic [IDX_W-1:0]  row_o_nx, col_o_nx;

    logic [DATA_W-1:0] cur_data;
    logic              cur_nz, slot_end, last_col, last_entry, wr_ok;

    assign cur_data   = mem[cur_row][cur_col];
    assign cur_nz     = (cur_data != '0);
    assign last_col   = (cur_col == IDX_W'(NUM_V - 1));
    assign last_entry = last_col && (cur_row == IDX_W'(NUM_V - 1));
    assign wr_ok      = (state == S_IDLE) && wr_en &&
                        (int'(wr_row) < NUM_V) && (int'(wr_col) < NUM_V);

`ifdef TGS_SKIP_ZERO_EN
    assign slot_end = phase || !cur_nz;
`else
    assign slot_end = phase;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_IDLE;
            cur_row    <= '0;
            cur_col    <= '0;
            phase      <= 1'b0;
            passes     <= '0;
            root_seen  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            task_array <= '0;
            row        <= '0;
            col        <= '0;
            root_task  <= 1'b0;
            app_end    <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_row    <= row_nx;
            cur_col    <= col_nx;
            phase      <= phase_nx;
            passes     <= passes_nx;
            root_seen  <= root_seen_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            task_array <= task_nx;
            row        <= row_o_nx;
            col        <= col_o_nx;
            root_task  <= root_nx;
            app_end    <= app_end_nx;
        end
    end

    // Outputs are registered from the current state, so the FSM runs one cycle ahead of the stream.
    always_comb begin
        state_nx     = state;
        row_nx       = cur_row;
        col_nx       = cur_col;
        phase_nx     = phase;
        passes_nx    = passes;
        root_seen_nx = root_seen;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        task_nx      = '0;
        row_o_nx     = '0;
        col_o_nx     = '0;
        root_nx      = 1'b0;
        app_end_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (app_count != '0) begin
                        state_nx     = S_EMIT;
                        passes_nx    = app_count;
                        row_nx       = '0;
                        col_nx       = '0;
                        phase_nx     = 1'b0;
                        root_seen_nx = 1'b0;
                    end else begin
                        state_nx = S_FIN;
                    end
                end
            end
            S_EMIT: begin
                busy_nx  = 1'b1;
                task_nx  = cur_data;
                row_o_nx = cur_row;
                col_o_nx = cur_col;
                root_nx  = cur_nz && !root_seen;
                if (slot_end) begin
                    phase_nx = 1'b0;
                    if (cur_nz)
                        root_seen_nx = 1'b1;
                    if (last_entry) begin
                        state_nx = S_END;
                    end else if (last_col) begin
                        col_nx = '0;
                        row_nx = cur_row + IDX_W'(1);
                    end else begin
                        col_nx = cur_col + IDX_W'(1);
                    end
                end else begin
                    phase_nx = 1'b1;
                end
            end
            S_END: begin
                busy_nx    = 1'b1;
                task_nx    = cur_data;
                row_o_nx   = cur_row;
                col_o_nx   = cur_col;
                app_end_nx = 1'b1;
                phase_nx   = !phase;
                if (phase)
                    state_nx = S_GAP;
            end
            S_GAP: begin
                busy_nx   = 1'b1;
                row_o_nx  = cur_row;
                col_o_nx  = cur_col;
                passes_nx = passes - CNT_W'(1);
                if (passes != CNT_W'(1)) begin
                    state_nx     = S_EMIT;
                    row_nx       = '0;
                    col_nx       = '0;
                    root_seen_nx = 1'b0;
                end else begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                done_nx  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A write arriving with an accepted start is parked until FIN so the run sees the old matrix.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem        <= '{default: '0};
            pend_valid <= 1'b0;
            pend_row   <= '0;
            pend_col   <= '0;
            pend_data  <= '0;
        end else begin
            if (wr_ok && start) begin
                pend_valid <= 1'b1;
                pend_row   <= wr_row;
                pend_col   <= wr_col;
                pend_data  <= wr_data;
            end else if (wr_ok) begin
                mem[wr_row][wr_col] <= wr_data;
            end else if (state == S_FIN && pend_valid) begin
                mem[pend_row][pend_col] <= pend_data;
                pend_valid              <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_task_graph_streamer.sv
// Directed bench for task_graph_streamer with NUM_V=2: a vector table for the first pass,
// then hand-written sequences for multi-pass, zero-count, reset-abort and all-zero runs.
module tb_task_graph_streamer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        wr_en;
    logic [0:0]  wr_row, wr_col;
    logic [31:0] wr_data;
    logic        start;
    logic [9:0]  app_count;
    logic        busy, done, root_task, app_end;
    logic [31:0] task_array;
    logic [0:0]  row, col;

    task_graph_streamer #(.NUM_V(2), .DATA_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .app_count(app_count), .busy(busy), .done(done),
        .task_array(task_array), .row(row), .col(col), .root_task(root_task), .app_end(app_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [0:0]  wr_row, wr_col;
        logic [31:0] wr_data;
        logic        start;
        logic [9:0]  cnt;
        logic [37:0] exp;
    } vec_t;

    vec_t        tab[$];
    logic [31:0] ref_m [4];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [37:0] pk(input logic b, input logic d, input logic rt, input logic ae,
                                       input logic r, input logic c, input logic [31:0] dat);
        return {b, d, rt, ae, r, c, dat};
    endfunction

    function automatic void add(input logic we, input logic r, input logic c, input logic [31:0] d,
                                input logic st, input logic [9:0] n, input logic [37:0] e);
        vec_t v;
        v.wr_en = we; v.wr_row = r; v.wr_col = c; v.wr_data = d;
        v.start = st; v.cnt = n; v.exp = e;
        tab.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmp(input string nm, input logic [37:0] e);
        logic [37:0] g;
        g = {busy, done, root_task, app_end, row, col, task_array};
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got busy=%0b done=%0b root=%0b end=%0b row=%0d col=%0d data=%0h, want busy=%0b done=%0b root=%0b end=%0b row=%0d col=%0d data=%0h",
                     nm, g[37], g[36], g[35], g[34], g[33], g[32], g[31:0],
                     e[37], e[36], e[35], e[34], e[33], e[32], e[31:0]);
        end
    endtask

    task automatic chk(input string nm, input int g, input int e);
        n_vec++;
        if (g != e) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, g, e);
        end
    endtask

    task automatic wr(input int r, input int c, input logic [31:0] d);
        wr_en = 1'b1; wr_row = 1'(r); wr_col = 1'(c); wr_data = d;
        step();
        wr_en = 1'b0;
        ref_m[r*2 + c] = d;
    endtask

    // Reference stream for one launch, built from the bench's own copy of the matrix.
    task automatic expect_stream(input int cnt, input string tag);
        int          len;
        logic        seen;
        logic [31:0] v;
        start = 1'b1; app_count = 10'(cnt);
        step();
        start = 1'b0; app_count = '0;
        cmp({tag, "/launch"}, '0);
        for (int p = 0; p < cnt; p++) begin
            seen = 1'b0;
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    v = ref_m[r*2 + c];
`ifdef TGS_SKIP_ZERO_EN
                    len = (v == 0) ? 1 : 2;
`else
                    len = 2;
`endif
                    for (int n = 0; n < len; n++) begin
                        step();
                        cmp($sformatf("%s/p%0d/e%0d%0d", tag, p, r, c),
                            pk(1, 0, (v != 0) && !seen, 0, 1'(r), 1'(c), v));
                    end
                    if (v != 0) seen = 1'b1;
                end
            end
            for (int n = 0; n < 2; n++) begin
                step();
                cmp($sformatf("%s/p%0d/app_end", tag, p), pk(1, 0, 0, 1, 1, 1, ref_m[3]));
            end
            step();
            cmp($sformatf("%s/p%0d/gap", tag, p), pk(1, 0, 0, 0, 1, 1, 0));
        end
        step();
        cmp({tag, "/done"}, pk(0, 1, 0, 0, 0, 0, 0));
        step();
        cmp({tag, "/idle"}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   found;
        int   seen_bad;

        rst_b = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        start = 1'b0; app_count = '0;
        for (int i = 0; i < 4; i++) ref_m[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        step();
        cmp("reset_state", '0);

        wr(0, 0, 0); wr(0, 1, 5); wr(1, 0, 5); wr(1, 1, 0);

        // Start with a same-cycle write to (1,1)=7; mid-stream start/write must be ignored.
`ifdef TGS_SKIP_ZERO_EN
        add(1, 1, 1, 7, 1, 1, '0);
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 1, 0, 0, 1, 5));
        add(1, 1, 0, 9, 1, 5, pk(1, 0, 1, 0, 0, 1, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 1, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 1, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, '0);
`else
        add(1, 1, 1, 7, 1, 1, '0);
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 1, 0, 0, 1, 5));
        add(1, 1, 0, 9, 1, 5, pk(1, 0, 1, 0, 0, 1, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 0, 5));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 1, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 1, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 1, 1, 0));
        add(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 0, 0, '0);
`endif
        foreach (tab[k]) begin
            wr_en = tab[k].wr_en; wr_row = tab[k].wr_row; wr_col = tab[k].wr_col;
            wr_data = tab[k].wr_data; start = tab[k].start; app_count = tab[k].cnt;
            step();
            cmp($sformatf("tab[%0d]", k), tab[k].exp);
        end
        wr_en = 1'b0; start = 1'b0; app_count = '0;
        ref_m[3] = 32'd7;

        expect_stream(3, "x3");
        expect_stream(0, "cnt0");

        // Reset during END of pass 1 of 2.
        start = 1'b1; app_count = 10'd2;
        step();
        start = 1'b0; app_count = '0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            step();
            if (app_end) found = 1;
        end
        chk("reset/reached_end", found, 1);
        rst_b = 1'b0;
        #1;
        cmp("reset/async_clear", '0);
        repeat (2) step();
        rst_b = 1'b1;
        seen_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done || busy) seen_bad++;
        end
        chk("reset/no_done", seen_bad, 0);
        for (int i = 0; i < 4; i++) ref_m[i] = '0;
        expect_stream(1, "zero_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
